// File: rtl/ble_scan_ctrl_pkg.sv
// ble_rx_pkg: shared types and constants for the BLE advertising-channel
// scan controller (FSM state encoding, advertising channel indices and the
// de-whitening LFSR seed layout).
package ble_rx_pkg;

  // FSM state encoding; also exported on the debug state port.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_LISTEN  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_HOLDOFF = 3'd4
  } scan_state_e;

  localparam int CH_W = 6;

  // Primary advertising channels, visited 37 -> 38 -> 39 -> 37.
  localparam logic [CH_W-1:0] CH_ADV37 = 6'd37;
  localparam logic [CH_W-1:0] CH_ADV38 = 6'd38;
  localparam logic [CH_W-1:0] CH_ADV39 = 6'd39;

  // De-whitening LFSR: 7 bits, seeded with bit 6 set and the channel
  // index in bits 5:0.
  localparam int LFSR_W = 7;

  function automatic logic [LFSR_W-1:0] lfsr_seed(input logic [CH_W-1:0] ch);
    logic [LFSR_W-1:0] seed;
    seed = {1'b1, ch};
    return seed;
  endfunction

  // Next channel in the advertising hop sequence; anything unexpected
  // falls back to the start of the sequence.
  function automatic logic [CH_W-1:0] next_adv_channel(input logic [CH_W-1:0] ch);
    logic [CH_W-1:0] nxt;
    case (ch)
      CH_ADV37: nxt = CH_ADV38;
      CH_ADV38: nxt = CH_ADV39;
      default:  nxt = CH_ADV37;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/ble_scan_ctrl_if.sv
// ble_scan_ctrl_if: bundle of the scan controller's control, CDR-facing and
// captured-data signals.
//
// Data handshake: byte_valid is a one-cycle qualifier with no back-pressure
// (there is no ready). byte_data is meaningful only in the cycle byte_valid
// is high and the consumer must take it in that cycle; pkt_done, when
// present, is asserted in the same cycle as the last byte_valid of a packet.
interface ble_scan_ctrl_if;
  import ble_rx_pkg::*;

  // Control and CDR core inputs
  logic            scan_start;
  logic            scan_stop;
  logic            packet_detected;
  logic            demod_symbol;
  logic            demod_symbol_clk;

  // CDR control and captured data outputs
  logic [CH_W-1:0] channel;
  logic            cdr_en;
  logic            cdr_rst_n;
  logic [7:0]      byte_data;
  logic            byte_valid;
  logic            pkt_done;
  logic            pkt_abort;
  logic [2:0]      state;

  // master: the side driving control/CDR signals and consuming bytes.
  modport master (
    output scan_start, scan_stop, packet_detected, demod_symbol, demod_symbol_clk,
    input  channel, cdr_en, cdr_rst_n, byte_data, byte_valid, pkt_done, pkt_abort, state
  );

  // slave: the scan controller itself.
  modport slave (
    input  scan_start, scan_stop, packet_detected, demod_symbol, demod_symbol_clk,
    output channel, cdr_en, cdr_rst_n, byte_data, byte_valid, pkt_done, pkt_abort, state
  );

endinterface

// File: rtl/ble_scan_ctrl_dewhiten.sv
// ble_dewhiten: 7-bit BLE data de-whitening LFSR. Load seeds it from the
// channel index, step advances it once per received symbol, o_bit is the
// whitening bit to XOR with the current symbol.
// Only compiled when BLE_SCAN_DEWHITEN_EN is defined; without the macro the
// scan controller carries no LFSR at all.
`ifdef BLE_SCAN_DEWHITEN_EN
module ble_dewhiten
  import ble_rx_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic [CH_W-1:0] i_channel,
  input  logic            i_step,
  output logic            o_bit
);

  logic [LFSR_W-1:0] r_lfsr;

  // Seed on load, otherwise advance one position per stepped symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= '0;
    end else if (i_load) begin
      r_lfsr <= lfsr_seed(i_channel);
    end else if (i_step) begin
      r_lfsr <= {r_lfsr[0], r_lfsr[6:5], r_lfsr[4] ^ r_lfsr[0], r_lfsr[3:1]};
    end
  end

  assign o_bit = r_lfsr[0];

endmodule
`endif

// File: rtl/ble_scan_ctrl.sv
// ble_scan_ctrl: BLE advertising-channel scan controller. Hops the CDR core
// across channels 37/38/39 (settle with CDR in reset, then listen for a
// dwell period), and on an access-address match captures CAPTURE_BYTES
// bytes from the recovered symbol stream, LSB first.
// Optional feature: define BLE_SCAN_DEWHITEN_EN to de-whiten captured bits
// with the channel-seeded LFSR (sub-module ble_dewhiten).
// Parameter ranges: DWELL_CYCLES >= 1, SETTLE_CYCLES >= 1, GAP_CYCLES >= 2,
// CAPTURE_BYTES >= 1.
module ble_scan_ctrl
  import ble_rx_pkg::*;
#(
  parameter int DWELL_CYCLES  = 4096,
  parameter int SETTLE_CYCLES = 32,
  parameter int GAP_CYCLES    = 64,
  parameter int CAPTURE_BYTES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  ble_scan_ctrl_if.slave  bus
);

  localparam int DWELL_W  = $clog2(DWELL_CYCLES + 1);
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam int BYTE_W   = $clog2(CAPTURE_BYTES + 1);
  localparam int BIT_W    = $clog2(8 + 1);

  localparam logic [DWELL_W-1:0]  DWELL_LAST  = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST    = GAP_W'(GAP_CYCLES - 1);
  localparam logic [BYTE_W-1:0]   BYTE_LAST   = BYTE_W'(CAPTURE_BYTES - 1);
  localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(7);

  scan_state_e          r_state;
  logic [CH_W-1:0]      r_channel;
  logic                 r_cdr_en;
  logic                 r_cdr_rst_n;
  logic [7:0]           r_byte_data;
  logic                 r_byte_valid;
  logic                 r_pkt_done;
  logic                 r_pkt_abort;
  logic [SETTLE_W-1:0]  r_settle_cnt;
  logic [DWELL_W-1:0]   r_dwell_cnt;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [BIT_W-1:0]     r_bit_cnt;
  logic [BYTE_W-1:0]    r_byte_cnt;
  logic [7:0]           r_shift;
  logic                 r_sym_clk_d;

  logic                 w_sym_edge;
  logic                 w_cap_bit;
  logic [7:0]           w_shift_next;

  // Registered copy of the symbol strobe for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sym_clk_d <= 1'b0;
    end else begin
      r_sym_clk_d <= bus.demod_symbol_clk;
    end
  end

  assign w_sym_edge = bus.demod_symbol_clk & ~r_sym_clk_d;

`ifdef BLE_SCAN_DEWHITEN_EN
  logic w_whiten_bit;
  logic w_lfsr_load;
  logic w_lfsr_step;

  // Seed on the LISTEN->CAPTURE transition (channel is not advanced on that
  // path), step on every accepted symbol edge while capturing.
  assign w_lfsr_load = (r_state == ST_LISTEN) & bus.packet_detected & ~bus.scan_stop;
  assign w_lfsr_step = (r_state == ST_CAPTURE) & w_sym_edge & ~bus.scan_stop;

  ble_dewhiten u_dewhiten (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_lfsr_load),
    .i_channel (r_channel),
    .i_step    (w_lfsr_step),
    .o_bit     (w_whiten_bit)
  );

  assign w_cap_bit = bus.demod_symbol ^ w_whiten_bit;
`else
  assign w_cap_bit = bus.demod_symbol;
`endif

  // Bits arrive LSB first: insert at the top and shift right, so after eight
  // edges the first received bit sits in bit 0.
  assign w_shift_next = {w_cap_bit, r_shift[7:1]};

  // Scan/capture FSM with all outputs registered alongside the state.
  // scan_stop overrides every transition. The gap counter holds the number
  // of cycles elapsed since the last symbol edge (capture entry counts as an
  // edge), so pkt_abort lands exactly GAP_CYCLES cycles after that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_channel    <= CH_ADV37;
      r_cdr_en     <= 1'b0;
      r_cdr_rst_n  <= 1'b0;
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_abort  <= 1'b0;
      r_settle_cnt <= '0;
      r_dwell_cnt  <= '0;
      r_gap_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_shift      <= '0;
    end else begin
      r_byte_valid <= 1'b0;
      r_pkt_done   <= 1'b0;
      r_pkt_abort  <= 1'b0;
      if (bus.scan_stop) begin
        r_state      <= ST_IDLE;
        r_channel    <= CH_ADV37;
        r_cdr_en     <= 1'b0;
        r_cdr_rst_n  <= 1'b0;
        r_settle_cnt <= '0;
        r_dwell_cnt  <= '0;
        r_gap_cnt    <= '0;
        r_bit_cnt    <= '0;
        r_byte_cnt   <= '0;
        r_shift      <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.scan_start) begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= '0;
            end
          end

          ST_SETTLE: begin
            if (r_settle_cnt == SETTLE_LAST) begin
              r_state      <= ST_LISTEN;
              r_settle_cnt <= '0;
              r_dwell_cnt  <= '0;
              r_cdr_en     <= 1'b1;
              r_cdr_rst_n  <= 1'b1;
            end else begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
            end
          end

          ST_LISTEN: begin
            // A detection in the expiry cycle still wins: stay on this channel.
            if (bus.packet_detected) begin
              r_state     <= ST_CAPTURE;
              r_dwell_cnt <= '0;
              r_gap_cnt   <= GAP_W'(1);
              r_bit_cnt   <= '0;
              r_byte_cnt  <= '0;
              r_shift     <= '0;
            end else if (r_dwell_cnt == DWELL_LAST) begin
              r_state      <= ST_SETTLE;
              r_dwell_cnt  <= '0;
              r_settle_cnt <= '0;
              r_channel    <= next_adv_channel(r_channel);
              r_cdr_en     <= 1'b0;
              r_cdr_rst_n  <= 1'b0;
            end else begin
              r_dwell_cnt <= r_dwell_cnt + 1'b1;
            end
          end

          ST_CAPTURE: begin
            if (w_sym_edge) begin
              r_gap_cnt <= GAP_W'(1);
              if (r_bit_cnt == BIT_LAST) begin
                r_bit_cnt    <= '0;
                r_shift      <= '0;
                r_byte_data  <= w_shift_next;
                r_byte_valid <= 1'b1;
                if (r_byte_cnt == BYTE_LAST) begin
                  r_pkt_done  <= 1'b1;
                  r_byte_cnt  <= '0;
                  r_gap_cnt   <= '0;
                  r_state     <= ST_HOLDOFF;
                  r_cdr_en    <= 1'b0;
                  r_cdr_rst_n <= 1'b0;
                end else begin
                  r_byte_cnt <= r_byte_cnt + 1'b1;
                end
              end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
                r_shift   <= w_shift_next;
              end
            end else if (r_gap_cnt == GAP_LAST) begin
              // Symbol stream stalled: drop the partial byte and re-arm.
              r_pkt_abort <= 1'b1;
              r_gap_cnt   <= '0;
              r_bit_cnt   <= '0;
              r_byte_cnt  <= '0;
              r_shift     <= '0;
              r_state     <= ST_HOLDOFF;
              r_cdr_en    <= 1'b0;
              r_cdr_rst_n <= 1'b0;
            end else begin
              r_gap_cnt <= r_gap_cnt + 1'b1;
            end
          end

          ST_HOLDOFF: begin
            // One idle cycle, then re-settle the CDR on the same channel.
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
          end

          default: begin
            r_state     <= ST_IDLE;
            r_channel   <= CH_ADV37;
            r_cdr_en    <= 1'b0;
            r_cdr_rst_n <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.channel    = r_channel;
  assign bus.cdr_en     = r_cdr_en;
  assign bus.cdr_rst_n  = r_cdr_rst_n;
  assign bus.byte_data  = r_byte_data;
  assign bus.byte_valid = r_byte_valid;
  assign bus.pkt_done   = r_pkt_done;
  assign bus.pkt_abort  = r_pkt_abort;
  assign bus.state      = r_state;

endmodule

// File: doc/ble_scan_ctrl.md
BLE_SCAN_CTRL -- requirements
Module: ble_scan_ctrl

Interface
REQ-001 Params: DWELL_CYCLES, default 4096, listen cycles per advertising channel; SETTLE_CYCLES, default 32, CDR hold-in-reset cycles after a channel change; GAP_CYCLES, default 64, max cycles between symbol strobes during capture; CAPTURE_BYTES, default 2, bytes captured per detected packet.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 scan_start  in  1  one-cycle pulse, begin scanning.
REQ-005 scan_stop  in  1  level/pulse, abort to IDLE.
REQ-006 packet_detected  in  1  from CDR core, access-address match.
REQ-007 demod_symbol  in  1  from CDR core, recovered bit.
REQ-008 demod_symbol_clk  in  1  from CDR core, symbol strobe (rising edge = bit valid).
REQ-009 channel  out  6  channel index driven to CDR.
REQ-010 cdr_en  out  1  CDR enable.
REQ-011 cdr_rst_n  out  1  CDR active-low reset.
REQ-012 byte_data  out  8  captured byte, LSB = first received bit.
REQ-013 byte_valid  out  1  one-cycle strobe qualifying byte_data.
REQ-014 pkt_done  out  1  one-cycle pulse, CAPTURE_BYTES bytes delivered.
REQ-015 pkt_abort  out  1  one-cycle pulse, capture abandoned on gap timeout.
REQ-016 state  out  3  current FSM state encoding (debug).

Function
REQ-017 FSM states: IDLE, SETTLE, LISTEN, CAPTURE, HOLDOFF.
REQ-018 IDLE: cdr_en=0, cdr_rst_n=0, channel=37; scan_start -> SETTLE.
REQ-019 SETTLE: cdr_en=0, cdr_rst_n=0 for exactly SETTLE_CYCLES cycles -> LISTEN.
REQ-020 LISTEN: cdr_en=1, cdr_rst_n=1; dwell counter counts DWELL_CYCLES; packet_detected -> CAPTURE; expiry -> advance channel 37->38->39->37 (wrap), -> SETTLE.
REQ-021 packet_detected in the same cycle as dwell expiry: CAPTURE wins, channel unchanged.
REQ-022 CAPTURE: symbol edge = demod_symbol_clk high and registered copy low; demod_symbol sampled in edge cycle, shifted in LSB-first.
REQ-023 byte_valid asserted the cycle after the 8th edge of each byte; byte_data stable while byte_valid high.
REQ-024 After the last byte: pkt_done pulses together with final byte_valid, -> HOLDOFF.
REQ-025 Gap counter resets on each edge; reaching GAP_CYCLES without an edge: pkt_abort pulse, partial byte discarded, -> HOLDOFF.
REQ-026 HOLDOFF: single cycle, cdr_en=0, -> SETTLE on same channel (CDR re-armed).
REQ-027 scan_stop has priority over every transition: next state IDLE, counters cleared, partial byte discarded, no pkt_done/pkt_abort issued.
REQ-028 scan_start ignored outside IDLE.
REQ-029 All counters sized clog2(param+1); no overflow permitted.

Reset
REQ-030 rst_n low: state=IDLE, channel=37, cdr_en=0, cdr_rst_n=0, byte_data=0, byte_valid=0, pkt_done=0, pkt_abort=0, all counters and shift register 0.
REQ-031 Reset mid-capture drops all in-flight data; no strobes emitted on release.

Configuration
REQ-032 Macro BLE_SCAN_DEWHITEN_EN defined: 7-bit LFSR s loaded at CAPTURE entry with s[6]=1, s[5:0]=channel; per edge, captured bit = demod_symbol XOR s[0], then s <= {s[0], s[6:5], s[4]^s[0], s[3:1]}.
REQ-033 Macro undefined: captured bit = demod_symbol, no LFSR logic synthesized.

Structure
REQ-034 Package ble_rx_pkg: FSM state enum, channel constants CH_ADV37/38/39, LFSR width and seed layout.
REQ-035 Sub-module ble_dewhiten (LFSR, load/step/out) instantiated only under BLE_SCAN_DEWHITEN_EN.

Verification
REQ-036 scan_start, no packet_detected, DWELL_CYCLES=100, SETTLE_CYCLES=4 -> channel sequence 37,38,39,37, each LISTEN exactly 100 cycles, cdr_rst_n low 4 cycles per change.
REQ-037 packet_detected on ch 38, then 16 symbols encoding 0xA5,0x3C LSB-first (macro off) -> byte_valid twice with 0xA5, 0x3C; pkt_done with second; re-SETTLE on 38.
REQ-038 Capture with symbols stopping after 5 bits, GAP_CYCLES=64 -> pkt_abort exactly 64 cycles after last edge, no byte_valid.
REQ-039 scan_stop asserted after 3rd captured bit -> IDLE next cycle, cdr_en=0, channel=37, no strobes.
REQ-040 packet_detected coincident with dwell expiry on ch 39 -> CAPTURE on 39, no advance.
REQ-041 Macro on, ch 37, all-zero symbols -> first byte equals first 8 LFSR outputs, first bit 1.
